// File: rtl/l2_bank_pkg.sv
// l2_bank_pkg: shared types and constants for the L2 bank controller.
//   RD_LAT_MIN / RD_LAT_MAX : legal range of the response latency
//   PORT_ID_W               : width of the port id carried in the response
//                             pipeline (supports up to 2**PORT_ID_W ports)
//   rsp_entry_t             : one response-pipeline slot
//   byte_parity()           : even-parity bit of one data byte
package l2_bank_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;
  localparam int PORT_ID_W  = 4;

  typedef struct packed {
    logic                 valid;
    logic [PORT_ID_W-1:0] port;
    logic                 oor;      // address fell outside the bank
    logic                 is_read;
  } rsp_entry_t;

  // Even parity: byte plus parity bit always hold an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/l2_rr_arb.sv
// l2_rr_arb: round-robin arbiter, one grant per cycle.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : per-port requests
//   gnt_o        : one-hot grant, combinational from req_i
//   gnt_any_o    : some port was granted this cycle
//   gnt_idx_o    : index of the granted port
// The search starts at rr_ptr; a grant moves rr_ptr just past the winner,
// no grant leaves it where it is. No grant is issued while rst_i is high.
module l2_rr_arb #(
  parameter  int NB_PORTS = 2,
  localparam int IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NB_PORTS-1:0] req_i,
  output logic [NB_PORTS-1:0] gnt_o,
  output logic                gnt_any_o,
  output logic [IDX_W-1:0]    gnt_idx_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    rr_ptr_d  = rr_ptr_q;
    for (int i = 0; i < NB_PORTS; i++) begin
      if (!rst_i && !found && req_i[(int'(rr_ptr_q) + i) % NB_PORTS]) begin
        found     = 1'b1;
        gnt_o[(int'(rr_ptr_q) + i) % NB_PORTS] = 1'b1;
        gnt_idx_o = IDX_W'((int'(rr_ptr_q) + i) % NB_PORTS);
        rr_ptr_d  = IDX_W'((int'(rr_ptr_q) + i + 1) % NB_PORTS);
      end
    end
  end

  assign gnt_any_o = found;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/l2_bank_ctrl.sv
// l2_bank_ctrl: shares one single-port SRAM bank between NB_PORTS requesters.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i/add_i/wen_i     : per-port request, byte address, 1=read 0=write
//   be_i/wdata_i          : per-port byte enables and {tag, data}
//   gnt_o                 : combinational one-hot grant
//   r_valid_o             : response for the granted port, RD_LATENCY later
//   r_rdata_o / r_opc_o   : shared read data and error flag (0 when idle)
//   mem_*                 : SRAM macro interface (active-low csn/wen/ben);
//                           mem_rdata_i arrives one cycle after the access
// Optional build macro L2_BANK_PARITY_EN: stores one even-parity bit per
// data byte above {tag, data} and flags any mismatch on reads in r_opc_o.
module l2_bank_ctrl
  import l2_bank_pkg::*;
#(
  parameter int          NB_PORTS   = 2,
  parameter int          ADDR_WIDTH = 15,
  parameter int          DATA_WIDTH = 32,
  parameter int          TAG_WIDTH  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,
  parameter int          RD_LATENCY = 1,
  localparam int NB_BYTES = DATA_WIDTH / 8,
  localparam int DT_W     = DATA_WIDTH + TAG_WIDTH,
`ifdef L2_BANK_PARITY_EN
  localparam int MEM_W    = DT_W + NB_BYTES,
`else
  localparam int MEM_W    = DT_W,
`endif
  localparam int IDX_W    = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NB_PORTS-1:0]          req_i,
  input  logic [NB_PORTS*32-1:0]       add_i,
  input  logic [NB_PORTS-1:0]          wen_i,
  input  logic [NB_PORTS*NB_BYTES-1:0] be_i,
  input  logic [NB_PORTS*DT_W-1:0]     wdata_i,
  output logic [NB_PORTS-1:0]          gnt_o,
  output logic [NB_PORTS-1:0]          r_valid_o,
  output logic [DT_W-1:0]              r_rdata_o,
  output logic                         r_opc_o,
  output logic                         mem_csn_o,
  output logic                         mem_wen_o,
  output logic [NB_BYTES-1:0]          mem_ben_o,
  output logic [ADDR_WIDTH-1:0]        mem_addr_o,
  output logic [MEM_W-1:0]             mem_wdata_o,
  input  logic [MEM_W-1:0]             mem_rdata_i
);

  genvar gi;

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
    $error("l2_bank_ctrl: RD_LATENCY out of range");
  end
  if (NB_PORTS > (1 << PORT_ID_W)) begin : g_bad_ports
    $error("l2_bank_ctrl: NB_PORTS exceeds port id width");
  end

  // ---------------- arbitration and winner mux ----------------
  logic             gnt_any;
  logic [IDX_W-1:0] gnt_idx;

  l2_rr_arb #(.NB_PORTS(NB_PORTS)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .gnt_any_o (gnt_any),
    .gnt_idx_o (gnt_idx)
  );

  logic [31:0]         sel_add;
  logic                sel_wen;
  logic [NB_BYTES-1:0] sel_be;
  logic [DT_W-1:0]     sel_wdata;

  always_comb begin
    sel_add   = '0;
    sel_wen   = 1'b1;
    sel_be    = '0;
    sel_wdata = '0;
    for (int p = 0; p < NB_PORTS; p++) begin
      if (gnt_o[p]) begin
        sel_add   = add_i[p*32 +: 32];
        sel_wen   = wen_i[p];
        sel_be    = be_i[p*NB_BYTES +: NB_BYTES];
        sel_wdata = wdata_i[p*DT_W +: DT_W];
      end
    end
  end

  // Offset wraps modulo 2**32, so addresses below the base land far out of
  // range rather than aliasing into the bank.
  logic [31:0] off;
  logic        oor;
  logic        unused_off_lsbs;
  assign off             = sel_add - BASE_ADDR;
  assign oor             = |off[31:ADDR_WIDTH+2];
  assign unused_off_lsbs = ^off[1:0];

  assign mem_csn_o  = ~(gnt_any & ~oor);
  assign mem_wen_o  = gnt_any ? sel_wen : 1'b1;
  assign mem_ben_o  = gnt_any ? ~sel_be : '1;
  assign mem_addr_o = off[ADDR_WIDTH+1:2];

`ifdef L2_BANK_PARITY_EN
  logic [NB_BYTES-1:0] wpar;
  always_comb begin
    wpar = '0;
    for (int b = 0; b < NB_BYTES; b++) wpar[b] = byte_parity(sel_wdata[b*8 +: 8]);
  end
  assign mem_wdata_o = {wpar, sel_wdata};
`else
  assign mem_wdata_o = sel_wdata;
`endif

  // ---------------- response pipeline ----------------
  rsp_entry_t pipe_in;
  rsp_entry_t pipe_q [RD_LATENCY];

  always_comb begin
    pipe_in         = '0;
    pipe_in.valid   = gnt_any;
    pipe_in.port    = PORT_ID_W'(gnt_idx);
    pipe_in.oor     = oor;
    pipe_in.is_read = sel_wen;
  end

  for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q[gi] <= '0;
        else       pipe_q[gi] <= pipe_in;
      end
    end else begin : g_body
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pipe_q[gi] <= '0;
        else       pipe_q[gi] <= pipe_q[gi-1];
      end
    end
  end

  // The macro already adds one cycle; extra latency is made up here so the
  // data lines up with the last pipeline slot.
  logic [MEM_W-1:0] rd_data;

  if (RD_LATENCY == 1) begin : g_rd_direct
    assign rd_data = mem_rdata_i;
  end else begin : g_rd_reg
    logic [MEM_W-1:0] rd_q [RD_LATENCY-1];
    for (gi = 0; gi < RD_LATENCY-1; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) rd_q[gi] <= '0;
          else       rd_q[gi] <= mem_rdata_i;
        end
      end else begin : g_next
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) rd_q[gi] <= '0;
          else       rd_q[gi] <= rd_q[gi-1];
        end
      end
    end
    assign rd_data = rd_q[RD_LATENCY-2];
  end

  logic par_err;
`ifdef L2_BANK_PARITY_EN
  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < NB_BYTES; b++)
      if (byte_parity(rd_data[b*8 +: 8]) != rd_data[DT_W+b]) par_err = 1'b1;
  end
`else
  assign par_err = 1'b0;
`endif

  rsp_entry_t rsp;
  assign rsp = pipe_q[RD_LATENCY-1];

  always_comb begin
    r_valid_o = '0;
    r_rdata_o = '0;
    r_opc_o   = 1'b0;
    if (rsp.valid) begin
      for (int p = 0; p < NB_PORTS; p++) r_valid_o[p] = (rsp.port == PORT_ID_W'(p));
      if (rsp.oor) begin
        r_opc_o = 1'b1;
      end else if (rsp.is_read) begin
        r_rdata_o = rd_data[DT_W-1:0];
        r_opc_o   = par_err;
      end
    end
  end

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// tb_l2_bank_ctrl: self-checking bench for l2_bank_ctrl (2 ports, 32-bit
// data, 4-bit tag, 15-bit word address). Main DUT uses RD_LATENCY=2, a
// second instance with RD_LATENCY=3 shares the inputs for the reset test.
// Honours L2_BANK_PARITY_EN for the memory width and the parity test.
module tb_l2_bank_ctrl;

  localparam int DW = 32, TW = 4, NBY = 4, DTW = 36, AW = 15, LAT = 2;
  localparam logic [31:0] BASE = 32'h1C00_0000;
`ifdef L2_BANK_PARITY_EN
  localparam int MW = DTW + NBY;
`else
  localparam int MW = DTW;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [1:0]    req_i = '0, wen_i = '0;
  logic [63:0]   add_i = '0;
  logic [7:0]    be_i = '0;
  logic [71:0]   wdata_i = '0;
  logic [1:0]    gnt_o, r_valid_o;
  logic [35:0]   r_rdata_o;
  logic          r_opc_o, mem_csn_o, mem_wen_o;
  logic [3:0]    mem_ben_o;
  logic [AW-1:0] mem_addr_o;
  logic [MW-1:0] mem_wdata_o, mem_rdata_i;

  logic [1:0]    d3_gnt, d3_rvalid;
  logic [35:0]   d3_unused_rdata;
  logic          d3_unused_opc, d3_unused_csn, d3_unused_wen;
  logic [3:0]    d3_unused_ben;
  logic [AW-1:0] d3_unused_addr;
  logic [MW-1:0] d3_unused_wdata;
  logic [MW-1:0] d3_rdata = '0;

  l2_bank_ctrl #(.NB_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                 .BASE_ADDR(BASE), .RD_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o), .r_opc_o(r_opc_o), .mem_csn_o(mem_csn_o),
    .mem_wen_o(mem_wen_o), .mem_ben_o(mem_ben_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i));

  l2_bank_ctrl #(.NB_PORTS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
                 .BASE_ADDR(BASE), .RD_LATENCY(3)) dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(d3_gnt), .r_valid_o(d3_rvalid),
    .r_rdata_o(d3_unused_rdata), .r_opc_o(d3_unused_opc), .mem_csn_o(d3_unused_csn),
    .mem_wen_o(d3_unused_wen), .mem_ben_o(d3_unused_ben), .mem_addr_o(d3_unused_addr),
    .mem_wdata_o(d3_unused_wdata), .mem_rdata_i(d3_rdata));

  // ---------------- write-first SRAM macro model ----------------
  logic [MW-1:0] mem [0:(1<<AW)-1];
  logic [MW-1:0] macro_rdata = '0;
  logic [MW-1:0] mw;
  logic          flip = 1'b0;

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

  always_comb begin
    mw = mem[mem_addr_o];
    for (int b = 0; b < NBY; b++) begin
      if (!mem_ben_o[b]) begin
        mw[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
`ifdef L2_BANK_PARITY_EN
        mw[DTW+b] = mem_wdata_o[DTW+b];
`endif
      end
    end
    mw[DTW-1:DW] = mem_wdata_o[DTW-1:DW];
  end

  always @(posedge clk_i) begin
    if (!mem_csn_o) begin
      if (!mem_wen_o) mem[mem_addr_o] <= mw;
      macro_rdata <= mem_wen_o ? mem[mem_addr_o] : mw;
    end
  end

  assign mem_rdata_i = macro_rdata ^ MW'(flip);

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [1:0]  req, wen;
    logic [31:0] a0, a1;
    logic [3:0]  b0, b1;
    logic [35:0] d0, d1;
    logic [1:0]  exp_gnt;
    logic        exp_csn;
    logic [35:0] exp_rd;
    logic        exp_opc;
  } vec_t;

  typedef struct {
    int          port;
    logic [35:0] rd;
    logic        opc;
    int          due;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_fail = 0, cyc = 0;
  bit   d3_quiet = 1'b0;

  function automatic vec_t mk(logic [1:0] req, logic [1:0] wen, logic [31:0] a0, logic [31:0] a1,
                              logic [3:0] b0, logic [3:0] b1, logic [35:0] d0, logic [35:0] d1,
                              logic [1:0] eg, logic ecsn, logic [35:0] erd, logic eopc);
    vec_t v;
    v.req = req; v.wen = wen; v.a0 = a0; v.a1 = a1; v.b0 = b0; v.b1 = b1;
    v.d0 = d0; v.d1 = d1; v.exp_gnt = eg; v.exp_csn = ecsn; v.exp_rd = erd; v.exp_opc = eopc;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_resp();
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      check("r_valid", r_valid_o, 64'(2'b01 << e.port));
      check("r_rdata", r_rdata_o, e.rd);
      check("r_opc", r_opc_o, e.opc);
    end else begin
      check("r_valid_idle", r_valid_o, 0);
      check("r_rdata_idle", r_rdata_o, 0);
      check("r_opc_idle", r_opc_o, 0);
    end
  endtask

  task automatic step(input vec_t v);
    logic [31:0] off;
    exp_t        e;
    req_i = v.req; wen_i = v.wen; add_i = {v.a1, v.a0};
    be_i = {v.b1, v.b0}; wdata_i = {v.d1, v.d0};
    @(negedge clk_i);
    check("gnt", gnt_o, v.exp_gnt);
    check("d3_gnt", d3_gnt, v.exp_gnt);
    check("mem_csn", mem_csn_o, v.exp_csn);
    if (v.exp_gnt != 2'b00) begin
      off = (v.exp_gnt[1] ? v.a1 : v.a0) - BASE;
      if (!v.exp_csn) check("mem_addr", mem_addr_o, off[16:2]);
      e.port = v.exp_gnt[1] ? 1 : 0;
      e.rd   = v.exp_rd;
      e.opc  = v.exp_opc;
      e.due  = cyc + LAT;
      sbq.push_back(e);
      $display("txn cyc=%0d port=%0d add=%h %s", cyc, e.port,
               v.exp_gnt[1] ? v.a1 : v.a0, (v.wen[e.port]) ? "rd" : "wr");
    end
    check_resp();
    if (d3_quiet) check("d3_rvalid_after_rst", d3_rvalid, 0);
    @(posedge clk_i); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1, 0, 1'b0));
  endtask

  task automatic do_reset();
    rst_i = 1'b1; req_i = 2'b11; wen_i = 2'b11;
    add_i = {32'h1C00_0020, 32'h1C00_0010}; be_i = '1; wdata_i = '0;
    sbq.delete();
    @(negedge clk_i);
    check("rst_gnt", gnt_o, 0);
    check("rst_d3_gnt", d3_gnt, 0);
    check("rst_csn", mem_csn_o, 1);
    check("rst_rvalid", r_valid_o, 0);
    check("rst_d3_rvalid", d3_rvalid, 0);
    check("rst_rdata", r_rdata_o, 0);
    check("rst_opc", r_opc_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cyc++;
  endtask

  vec_t tv[13];

  initial begin
    tv[0]  = mk(2'b01, 2'b00, 32'h1C00_0010, 0, 4'hF, 0, {4'h5, 32'hDEADBEEF}, 0, 2'b01, 1'b0, 0, 1'b0);
    tv[1]  = mk(2'b01, 2'b01, 32'h1C00_0010, 0, 4'hF, 0, 0, 0, 2'b01, 1'b0, {4'h5, 32'hDEADBEEF}, 1'b0);
    tv[2]  = mk(2'b10, 2'b00, 0, 32'h1C00_0020, 0, 4'hF, 0, {4'hA, 32'h11223344}, 2'b10, 1'b0, 0, 1'b0);
    tv[3]  = mk(2'b10, 2'b00, 0, 32'h1C00_0020, 0, 4'b0010, 0, {4'hA, 32'h0000AB00}, 2'b10, 1'b0, 0, 1'b0);
    tv[4]  = mk(2'b10, 2'b10, 0, 32'h1C00_0020, 0, 4'hF, 0, 0, 2'b10, 1'b0, {4'hA, 32'h1122AB44}, 1'b0);
    tv[5]  = mk(2'b01, 2'b01, 32'h1C02_0000, 0, 4'hF, 0, 0, 0, 2'b01, 1'b1, 0, 1'b1);
    tv[6]  = mk(2'b01, 2'b01, 32'h1C01_FFFC, 0, 4'hF, 0, 0, 0, 2'b01, 1'b0, 0, 1'b0);
    tv[7]  = mk(2'b10, 2'b10, 0, 32'h1BFF_FFFC, 0, 4'hF, 0, 0, 2'b10, 1'b1, 0, 1'b1);
    tv[8]  = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1'b1, 0, 1'b0);
    tv[9]  = mk(2'b01, 2'b00, 32'h1C00_0013, 0, 4'hF, 0, {4'h3, 32'hCAFEF00D}, 0, 2'b01, 1'b0, 0, 1'b0);
    tv[10] = mk(2'b10, 2'b10, 0, 32'h1C00_0010, 0, 4'hF, 0, 0, 2'b10, 1'b0, {4'h3, 32'hCAFEF00D}, 1'b0);
    tv[11] = mk(2'b11, 2'b11, 32'h1C00_0000, 32'h1C00_0020, 4'hF, 4'hF, 0, 0, 2'b01, 1'b0, 0, 1'b0);
    tv[12] = mk(2'b11, 2'b11, 32'h1C00_0000, 32'h1C00_0020, 4'hF, 4'hF, 0, 0, 2'b10, 1'b0, {4'hA, 32'h1122AB44}, 1'b0);

    @(posedge clk_i); #1;
    do_reset();

    // Table: back-to-back traffic, one vector per cycle.
    for (int i = 0; i < 13; i++) step(tv[i]);
    idle(LAT + 1);

    // Both ports requesting continuously straight out of reset.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk(2'b11, 2'b11, 32'h1C00_0010, 32'h1C00_0020, 4'hF, 4'hF, 0, 0,
              (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0,
              (i % 2 == 0) ? {4'h3, 32'hCAFEF00D} : {4'hA, 32'h1122AB44}, 1'b0));
    idle(LAT + 1);

    // Reset one cycle after a grant: in-flight responses vanish, rr_ptr restarts.
    step(mk(2'b01, 2'b01, 32'h1C00_0010, 0, 4'hF, 0, 0, 0, 2'b01, 1'b0, {4'h3, 32'hCAFEF00D}, 1'b0));
    do_reset();
    d3_quiet = 1'b1;
    idle(4);
    d3_quiet = 1'b0;
    step(mk(2'b11, 2'b11, 32'h1C00_0010, 32'h1C00_0020, 4'hF, 4'hF, 0, 0, 2'b01, 1'b0,
            {4'h3, 32'hCAFEF00D}, 1'b0));
    idle(LAT + 1);

`ifdef L2_BANK_PARITY_EN
    // Corrupt bit 0 of byte 0 on the way back from the macro.
    flip = 1'b1;
    step(mk(2'b01, 2'b01, 32'h1C00_0010, 0, 4'hF, 0, 0, 0, 2'b01, 1'b0, {4'h3, 32'hCAFEF00C}, 1'b1));
    idle(LAT + 1);
    flip = 1'b0;
`endif

    check("scoreboard_empty", 64'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_bank_ctrl.md
L2_BANK_CTRL -- requirements
Module: l2_bank_ctrl

Interface
REQ-001 SHALL have parameter NB_PORTS, default 2: number of requesters sharing one bank.
REQ-002 SHALL have parameter ADDR_WIDTH, default 15: bank word-address width, so bank depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: data width, a multiple of 8.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: tag bits carried alongside the data.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h1C00_0000: byte base address of the bank.
REQ-006 SHALL have parameter RD_LATENCY, default 1, legal range 1..3: number of cycles from grant to response.
REQ-007 SHALL have the following ports (name, direction, width, meaning).
- clk_i, in, 1: the single clock.
- rst_i, in, 1: asynchronous active-high reset.
- req_i, in, NB_PORTS: per-port request.
- add_i, in, NB_PORTS x 32: byte address.
- wen_i, in, NB_PORTS: 1 = read, 0 = write.
- be_i, in, NB_PORTS x DATA_WIDTH/8: byte enables.
- wdata_i, in, NB_PORTS x (DATA_WIDTH+TAG_WIDTH): write data with tag in the MSBs.
- gnt_o, out, NB_PORTS: grant, combinational.
- r_valid_o, out, NB_PORTS: response valid.
- r_rdata_o, out, DATA_WIDTH+TAG_WIDTH: read data, shared across ports.
- r_opc_o, out, 1: error flag, qualified by r_valid_o.
- mem_csn_o, out, 1: macro chip select, active-low.
- mem_wen_o, out, 1: macro write enable, 0 = write.
- mem_ben_o, out, DATA_WIDTH/8: macro byte enables, active-low.
- mem_addr_o, out, ADDR_WIDTH: macro word address.
- mem_wdata_o, out, MEM_W: macro write data.
- mem_rdata_i, in, MEM_W: macro read data, valid one cycle after access.

Function
REQ-008 SHALL grant at most one port per cycle; gnt_o goes high in the same cycle as req_i.
REQ-009 SHALL arbitrate round-robin: search starts at rr_ptr; after a grant, rr_ptr = winner+1 mod NB_PORTS; with no grant, rr_ptr holds.
REQ-010 SHALL compute off = add_i - BASE_ADDR, 32-bit modulo; mem_addr_o = off[ADDR_WIDTH+1:2]; off[1:0] is ignored.
REQ-011 SHALL treat off >= 4*2**ADDR_WIDTH as out-of-range: grant it, keep mem_csn_o=1, and respond with r_opc_o=1 and r_rdata_o=0.
REQ-012 SHALL, for an in-range grant, drive mem_csn_o=0 in the grant cycle, with mem_wen_o, mem_ben_o=~be_i and mem_wdata_o taken from the winner.
REQ-013 SHALL assert r_valid_o for the granting port exactly RD_LATENCY cycles after the grant, for reads and writes alike.
REQ-014 SHALL clear r_rdata_o to 0 for writes; reads return the word stored at that address.
REQ-015 SHALL carry {valid, port id, out-of-range, is-read} through a RD_LATENCY-deep shift register; when RD_LATENCY>1, mem_rdata_i is registered RD_LATENCY-1 times.
REQ-016 SHALL sustain back-to-back grants at full throughput, one response per cycle and never more than one r_valid_o bit set per cycle.
REQ-017 SHALL return the new data on a read of an address written in the immediately preceding cycle, the macro being write-first.
REQ-018 SHALL leave r_rdata_o and r_opc_o undefined-free (0) whenever no r_valid_o bit is set.

Reset
REQ-019 SHALL, while rst_i=1, force r_valid_o=0, r_opc_o=0, r_rdata_o=0, rr_ptr=0 and mem_csn_o=1, and empty the pipeline.
REQ-020 SHALL drop responses in flight when reset asserts mid-operation; no r_valid_o appears after reset is released.
REQ-021 SHALL hold gnt_o=0 while rst_i=1.

Configuration
REQ-022 SHALL, with L2_BANK_PARITY_EN defined, set MEM_W = DATA_WIDTH+TAG_WIDTH+DATA_WIDTH/8 and store one even-parity bit per data byte.
REQ-023 SHALL, with L2_BANK_PARITY_EN defined, check the parity of bytes enabled... (all bytes) on every in-range read and set r_opc_o=1 on any mismatch, with data still returned.
REQ-024 SHALL, without L2_BANK_PARITY_EN, set MEM_W = DATA_WIDTH+TAG_WIDTH; r_opc_o then reflects out-of-range only.

Structure
REQ-025 SHALL place the response-pipeline entry typedef and the RD_LATENCY bound constants in package l2_bank_pkg.
REQ-026 SHALL implement the round-robin arbiter as sub-module l2_rr_arb, parameterised by NB_PORTS.

Verification
REQ-027 SHALL cover: port0 writes 32'hDEADBEEF (be=4'hF) to 0x1C00_0010, then reads it with RD_LATENCY=2 -> r_valid_o[0] two cycles after grant and r_rdata_o[31:0]=32'hDEADBEEF.
REQ-028 SHALL cover: both ports request continuously for 4 cycles from reset -> grants 0,1,0,1 and r_valid_o in the same order.
REQ-029 SHALL cover: read of 0x1C02_0000 with ADDR_WIDTH=15 -> mem_csn_o stays 1, r_opc_o=1, r_rdata_o=0.
REQ-030 SHALL cover: be=4'b0010 write of 32'h0000AB00 over 32'h11223344 -> read returns 32'h1122AB44.
REQ-031 SHALL cover: rst_i pulsed one cycle after a grant with RD_LATENCY=3 -> no r_valid_o observed afterward, and rr_ptr=0.
REQ-032 SHALL cover, with L2_BANK_PARITY_EN: flip bit 0 of mem_rdata_i byte 0 -> r_opc_o=1 alongside r_valid_o.
